bcd_stopwatch_timer: RTL

//  Parametrised N-digit BCD stopwatch/countdown timer on one system clock (no ripple clocks).

---
 rtl/bcd_timer_pkg.sv | 20 ++
 rtl/bcd_digit.sv | 37 +++
 rtl/bcd_stopwatch_timer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD stopwatch/countdown timer.
package bcd_timer_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [15:0] DEFAULT_DIGIT_MAX = 16'h5959;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Preset nibbles above a digit's modulus clamp to that digit's maximum.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] v,
                                                   input logic [DIGIT_W-1:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with its own modulus, wrapping inc/dec and saturating load.
module bcd_digit
  import bcd_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               inc,
  input  logic               dec,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] val,
  output logic               at_max,
  output logic               at_zero
);

  logic [DIGIT_W-1:0] val_reg;

  assign val     = val_reg;
  assign at_max  = (val_reg == MAX);
  assign at_zero = (val_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      val_reg <= '0;
    end else if (load) begin
      val_reg <= sat_digit(ld_val, MAX);
    end else if (en && inc) begin
      val_reg <= at_max ? '0 : val_reg + DIGIT_W'(1);
    end else if (en && dec) begin
      val_reg <= at_zero ? MAX : val_reg - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_stopwatch_timer.sv
// N-digit BCD stopwatch / countdown timer: prescaler, run/pause/done FSM,
// digit chain with carry/borrow ripple, and lap capture register.
module bcd_stopwatch_timer
  import bcd_timer_pkg::*;
#(
  parameter int                       NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0]  DIGIT_MAX  = DEFAULT_DIGIT_MAX,
  parameter int                       TICK_DIV   = 100_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic                      mode_down,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_val,
  input  logic                      lap,
  output logic [4*NUM_DIGITS-1:0]   bcd_num,
  output logic [4*NUM_DIGITS-1:0]   lap_num,
  output logic                      lap_valid,
  output logic                      running,
  output logic                      tick,
  output logic                      wrap,
  output logic                      done
);

  localparam int COUNT_W = DIGIT_W * NUM_DIGITS;
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

  state_t               state_reg;
  logic                 mode_down_reg;
  logic [PRESC_W-1:0]   presc_reg;
  logic                 running_reg;
  logic                 done_reg;
  logic                 wrap_reg;
  logic [COUNT_W-1:0]   lap_num_reg;
  logic                 lap_valid_reg;

  logic [COUNT_W-1:0]   count_val;
  logic [NUM_DIGITS-1:0] at_max_vec;
  logic [NUM_DIGITS-1:0] at_zero_vec;
  logic [NUM_DIGITS:0]  carry;
  logic [NUM_DIGITS:0]  borrow;

  logic in_run, presc_last, load_ok, stop_ok, start_ok;
  logic tick_fire, count_en, wrap_fire, hit_zero, lap_fire, digit_load;
  logic all_max, all_zero;

  // Command arbitration: clear > load > stop > start > tick/lap.
  assign in_run     = (state_reg == ST_RUN);
  assign presc_last = (presc_reg == PRESC_LAST);
  assign load_ok    = load && !clear && !in_run;
  assign stop_ok    = stop && !clear && in_run;
  assign start_ok   = start && !clear && !load_ok && !stop_ok &&
                      (state_reg == ST_IDLE || state_reg == ST_PAUSE);
  assign tick_fire  = in_run && presc_last && !clear && !stop_ok;
  assign all_max    = carry[NUM_DIGITS];
  assign all_zero   = borrow[NUM_DIGITS];
  // A down tick at all-zero must not borrow through to max.
  assign count_en   = tick_fire && (!mode_down_reg || !all_zero);
  assign wrap_fire  = tick_fire && !mode_down_reg && all_max;
  assign hit_zero   = tick_fire && mode_down_reg && (all_zero || count_val == COUNT_ONE);
  assign lap_fire   = lap && !clear && !load_ok && (state_reg != ST_IDLE);
  assign digit_load = clear || load_ok;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit #(
        .MAX(DIGIT_MAX[gi*DIGIT_W +: DIGIT_W])
      ) u_digit (
        .clk     (clk),
        .rst     (rst),
        .en      (count_en),
        .inc     (!mode_down_reg && carry[gi]),
        .dec     (mode_down_reg && borrow[gi]),
        .load    (digit_load),
        .ld_val  (clear ? {DIGIT_W{1'b0}} : load_val[gi*DIGIT_W +: DIGIT_W]),
        .val     (count_val[gi*DIGIT_W +: DIGIT_W]),
        .at_max  (at_max_vec[gi]),
        .at_zero (at_zero_vec[gi])
      );
      assign carry[gi+1]  = carry[gi] & at_max_vec[gi];
      assign borrow[gi+1] = borrow[gi] & at_zero_vec[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      mode_down_reg <= 1'b0;
      presc_reg     <= '0;
      running_reg   <= 1'b0;
      done_reg      <= 1'b0;
      wrap_reg      <= 1'b0;
      lap_num_reg   <= '0;
      lap_valid_reg <= 1'b0;
    end else begin
      wrap_reg      <= wrap_fire;
      lap_valid_reg <= lap_fire;
      if (lap_fire) begin
        lap_num_reg <= count_val;
      end

      // Prescaler phase survives PAUSE so resume finishes the partial tick.
      if (clear) begin
        presc_reg <= '0;
      end else if (in_run && !stop_ok) begin
        presc_reg <= presc_last ? '0 : presc_reg + PRESC_W'(1);
      end

      if (clear) begin
        state_reg   <= ST_IDLE;
        running_reg <= 1'b0;
        done_reg    <= 1'b0;
      end else if (load_ok) begin
        if (state_reg == ST_DONE) begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end
      end else if (stop_ok) begin
        state_reg   <= ST_PAUSE;
        running_reg <= 1'b0;
      end else if (start_ok) begin
        if (state_reg == ST_IDLE) begin
          mode_down_reg <= mode_down;
          if (mode_down && all_zero) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg   <= ST_RUN;
            running_reg <= 1'b1;
          end
        end else begin
          state_reg   <= ST_RUN;
          running_reg <= 1'b1;
        end
      end else if (hit_zero) begin
        state_reg   <= ST_DONE;
        running_reg <= 1'b0;
        done_reg    <= 1'b1;
      end
    end
  end

  assign bcd_num   = count_val;
  assign lap_num   = lap_num_reg;
  assign lap_valid = lap_valid_reg;
  assign running   = running_reg;
  assign done      = done_reg;
  assign wrap      = wrap_reg;
  assign tick      = in_run && presc_last;

endmodule
